seq_mult_writer: RTL and testbench



---
 rtl/seq_mult_writer.sv | 133 +++++++++++++
 tb/tb_seq_mult_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_writer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_writer
//  Purpose  : Shift-and-add unsigned multiplier that retires one multiplier
//             bit per clock, then performs a single-cycle write of the
//             2*WIDTH-bit product into a register-file write port.
//  Options  : SEQMUL_ZERO_SKIP_EN - a zero operand bypasses the CALC phase
//             and writes 0 on the cycle after the start is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult_writer #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    input  logic [ADDR_W-1:0]    dest,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [2*WIDTH-1:0]   wr_data,
    output logic [2*WIDTH-1:0]   product
);

    localparam int         CNT_W    = $clog2(WIDTH + 1);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]          state_q,   state_d;
    logic [WIDTH-1:0]    m_q,       m_d;
    logic [WIDTH-1:0]    a_q,       a_d;
    logic [WIDTH-1:0]    q_q,       q_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [2*WIDTH-1:0]  product_q, product_d;

    // Carry-extended partial sum {c,a} for the current CALC step
    logic [WIDTH:0]      w_acc;
    logic                w_zero_skip;

`ifdef SEQMUL_ZERO_SKIP_EN
    // A zero operand makes the product trivially zero
    assign w_zero_skip = (op1 == '0) || (op2 == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // State and datapath registers; async reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            product_q <= product_d;
        end
    end

    // Next-state decode: start only honoured in IDLE, WIDTH CALC edges, one WRITE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = w_zero_skip ? ST_WRITE : ST_CALC;
            ST_CALC:  if (cnt_q == CNT_W'(1)) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, conditional add then right shift of {c,a,q}
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        product_d = product_q;
        w_acc     = {1'b0, a_q};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d    = op1;
                    q_d    = w_zero_skip ? '0 : op2;
                    a_d    = '0;
                    addr_d = dest;
                    cnt_d  = CNT_W'(WIDTH);
                end
            end
            ST_CALC: begin
                if (q_q[0]) w_acc = {1'b0, a_q} + {1'b0, m_q};
                a_d   = w_acc[WIDTH:1];
                q_d   = {w_acc[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_WRITE: begin
                product_d = {a_q, q_q};
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state; write bus is zero outside WRITE
    always_comb begin
        busy    = (state_q != ST_IDLE);
        wr_en   = (state_q == ST_WRITE);
        done    = (state_q == ST_WRITE);
        wr_addr = '0;
        wr_data = '0;
        if (state_q == ST_WRITE) begin
            wr_addr = addr_q;
            wr_data = {a_q, q_q};
        end
    end

    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mult_writer
//  Purpose  : Scoreboard bench for seq_mult_writer. Stimulus predicts every
//             write (address, product, cycle) from plain arithmetic; a
//             negedge monitor compares the DUT against those predictions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_writer;

    localparam int WIDTH  = 4;
    localparam int ADDR_W = 4;
`ifdef SEQMUL_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    op1, op2;
    logic [ADDR_W-1:0]   dest;
    logic                busy, done, wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [2*WIDTH-1:0]  wr_data, product;

    seq_mult_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op1(op1), .op2(op2), .dest(dest),
        .busy(busy), .done(done), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .product(product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int t; } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    // Reference model of the operation in flight
    int free_edge = 0, busy_from = 1, busy_to = 0;
    int prod_at = 1 << 30, prod_val = 0, prod_shown = 0;

    task automatic chk(input string nm, input integer act, input integer exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every output on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prod_shown = 0;
        end else begin
            if (cyc >= prod_at) prod_shown = prod_val;
            if (sb.size() > 0 && sb[0].t < cyc) begin
                chk("write_time", cyc, sb[0].t);
                void'(sb.pop_front());
            end
            chk("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
            chk("wr_en", wr_en, (sb.size() > 0 && sb[0].t == cyc) ? 1 : 0);
            chk("done", done, (sb.size() > 0 && sb[0].t == cyc) ? 1 : 0);
            if (wr_en && sb.size() > 0 && sb[0].t == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end else if (!wr_en) begin
                chk("idle_wr_data", wr_data, 0);
                chk("idle_wr_addr", wr_addr, 0);
            end
            chk("product", product, prod_shown);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Pulse start for one cycle; the model decides whether it is accepted
    task automatic do_start(input int a, input int b, input int d, output bit acc);
        int e;
        int lat;
        e = cyc + 1;
        op1 = a[WIDTH-1:0]; op2 = b[WIDTH-1:0]; dest = d[ADDR_W-1:0];
        start = 1'b1;
        acc = (e >= free_edge);
        if (acc) begin
            lat = (ZS && (a == 0 || b == 0)) ? 0 : WIDTH;
            sb.push_back('{addr: d, data: a * b, t: e + lat});
            free_edge = e + lat + 2;
            busy_from = e;
            busy_to   = e + lat;
            prod_at   = e + lat + 1;
            prod_val  = a * b;
        end
        idle(1);
        start = 1'b0;
        op1 = WIDTH'($urandom_range(15));
        op2 = WIDTH'($urandom_range(15));
        dest = ADDR_W'($urandom_range(15));
    endtask

    task automatic wait_free();
        int k;
        k = 0;
        while (cyc + 1 < free_edge && k < 50) begin idle(1); k++; end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_product", product, 0);
    endtask

    initial begin
        bit acc;
        int k;
        rst_n = 1'b0; start = 1'b0; op1 = '0; op2 = '0; dest = '0;
        #1;
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Directed cases
        do_start(8, 2, 5, acc);    chk("accept_8x2", acc, 1);
        wait_free();
        do_start(15, 15, 15, acc); chk("accept_15x15", acc, 1);
        wait_free();
        do_start(5, 3, 6, acc);    // re-pulse while busy must be ignored
        idle(1);
        do_start(4, 4, 7, acc);    chk("reject_busy", acc, 0);
        wait_free();
        do_start(4, 0, 9, acc);
        wait_free();

        // Abort mid-CALC with an asynchronous reset
        do_start(7, 9, 3, acc);
        idle(2);
        rst_n = 1'b0;
        busy_from = 1; busy_to = 0; prod_at = 1 << 30; prod_val = 0; free_edge = 0;
        #1;
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        do_start(7, 9, 3, acc);
        wait_free();

        // Back-to-back: start on the edge leaving WRITE is dropped, next edge accepted
        do_start(4, 2, 1, acc);
        while (cyc + 2 < free_edge) idle(1);
        do_start(9, 9, 4, acc);    chk("reject_leaving_write", acc, 0);
        do_start(3, 5, 2, acc);    chk("accept_after_gap", acc, 1);
        wait_free();

        // Random traffic, start attempts also landing while busy
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) begin
                int a, b;
                a = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(15));
                b = ($urandom_range(5) == 0) ? 15 : int'($urandom_range(15));
                do_start(a, b, int'($urandom_range(15)), acc);
            end else begin
                idle(1);
            end
        end

        k = 0;
        while (sb.size() > 0 && k < 50) begin idle(1); k++; end
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
